// File: rtl/window_stream_packer_pkg.sv
// Shared types for the window stream packer: FSM states, word width and FIFO entry layout.
package window_stream_packer_pkg;

  localparam int unsigned WordWidth  = 32;
  localparam int unsigned EntryWidth = WordWidth + 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StStopping = 2'd2
  } state_t;

  typedef struct packed {
    logic [WordWidth-1:0] data;
    logic                 eol;
    logic                 eof;
  } fifo_entry_t;

endpackage

// File: rtl/window_stream_packer_word_fifo.sv
// Synchronous word FIFO holding packed words with their eol/eof tags; head is shown combinationally.
module word_fifo
  import window_stream_packer_pkg::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;

  fifo_entry_t   r_mem [depth];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= (r_wr == PW'(depth - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= (r_rd == PW'(depth - 1)) ? '0 : r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr] <= push_data;
    end
  end

  assign head  = r_mem[r_rd];
  assign full  = (r_count == (PW + 1)'(depth));
  assign empty = (r_count == '0);

endmodule

// File: rtl/window_stream_packer.sv
// Packs accepted 8-bit window pixels into 32-bit words tagged with end-of-line/end-of-frame,
// buffered in a small FIFO with a sticky overflow flag.
module window_stream_packer
  import window_stream_packer_pkg::*;
#(
  parameter int unsigned width  = 420,
  parameter int unsigned height = 240,
  parameter int unsigned depth  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           din,
  input  logic                 blanking_in,
  input  logic                 validin,
  input  logic                 enable,
  output logic [WordWidth-1:0] word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 word_eol,
  output logic                 word_eof,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned XW = (width > 1) ? $clog2(width) : 1;
  localparam int unsigned YW = (height > 1) ? $clog2(height) : 1;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_lane;
  logic [23:0]   r_word;
  logic          r_push;
  fifo_entry_t   r_push_entry;
  logic          r_overflow;

  fifo_entry_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_x_last;
  logic        w_y_last;
  logic        w_final;
  logic        w_pop;
  logic        w_drop;

  assign w_accept = validin && !blanking_in && (r_state != StIdle);
  assign w_x_last = (r_x == XW'(width - 1));
  assign w_y_last = (r_y == YW'(height - 1));
  assign w_final  = w_accept && w_x_last && w_y_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (enable) r_state <= StActive;
        end
        StActive: begin
          if (!enable) r_state <= w_final ? StIdle : StStopping;
        end
        StStopping: begin
          if (w_final) r_state <= StIdle;
          else if (enable) r_state <= StActive;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_lane <= '0;
      r_word <= '0;
    end else if (r_state == StIdle) begin
      r_x    <= '0;
      r_y    <= '0;
      r_lane <= '0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      r_x    <= w_x_last ? '0 : r_x + 1'b1;
      if (w_x_last) begin
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end
      // Lane 3 bypasses r_word and goes straight into the push register.
      case (r_lane)
        2'd0:    r_word[7:0]   <= din;
        2'd1:    r_word[15:8]  <= din;
        2'd2:    r_word[23:16] <= din;
        default: r_word        <= r_word;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_push       <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_push <= w_accept && (r_lane == 2'd3);
      if (w_accept && (r_lane == 2'd3)) begin
        r_push_entry <= '{data: {din, r_word}, eol: w_x_last, eof: w_x_last && w_y_last};
      end
    end
  end

  assign w_pop  = word_valid && word_ready;
  assign w_drop = r_push && w_full && !w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  word_fifo #(
    .depth(depth)
  ) u_word_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (r_push),
    .push_data(r_push_entry),
    .pop      (w_pop),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Outputs are forced to zero while empty so reset and idle present clean values.
  assign word_valid = !w_empty;
  assign word_data  = word_valid ? w_head.data : '0;
  assign word_eol   = word_valid && w_head.eol;
  assign word_eof   = word_valid && w_head.eof;
  assign overflow   = r_overflow;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_window_stream_packer.sv
// Scoreboard bench: a pixel-list reference model queues expected words; a negedge monitor checks.
module tb_window_stream_packer;

  localparam int unsigned W     = 8;
  localparam int unsigned H     = 2;
  localparam int unsigned D     = 4;
  localparam int unsigned FRAME = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = '0;
  logic        blanking_in = 1'b0;
  logic        validin = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        word_eol;
  logic        word_eof;
  logic        overflow;
  logic        busy;

  always #5 clock = ~clock;

  window_stream_packer #(
    .width (W),
    .height(H),
    .depth (D)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .blanking_in(blanking_in),
    .validin    (validin),
    .enable     (enable),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_eol   (word_eol),
    .word_eof   (word_eof),
    .overflow   (overflow),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        eol;
    logic        eof;
  } exp_t;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0 idle, 1 packing, 2 finishing the frame after enable fell.
  exp_t       exp_q[$];
  logic [7:0] m_pix[$];
  int         m_mode = 0;
  int         m_pcount = 0;
  bit         m_pend = 0;
  exp_t       m_pend_e;
  bit         m_ovf = 0;
  bit         m_pop, m_acc, m_fin;
  exp_t       m_e;

  int          n_hs = 0;
  int          n_eol = 0;
  int          n_eof = 0;
  logic [31:0] last_data = '0;
  logic        last_eof = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        m_pix.delete();
        m_mode   = 0;
        m_pcount = 0;
        m_pend   = 0;
        m_ovf    = 0;
      end else begin
        chk("busy", busy, 32'(m_mode != 0));
        chk("overflow", overflow, 32'(m_ovf));
        chk("word_valid", word_valid, 32'(exp_q.size() != 0));
        if (word_valid && exp_q.size() != 0) begin
          chk("word_data", word_data, exp_q[0].data);
          chk("word_eol", word_eol, 32'(exp_q[0].eol));
          chk("word_eof", word_eof, 32'(exp_q[0].eof));
        end
        if (word_valid && word_ready) begin
          n_hs++;
          if (word_eol) n_eol++;
          if (word_eof) n_eof++;
          last_data = word_data;
          last_eof  = word_eof;
        end
        m_pop = (exp_q.size() != 0) && word_ready;
        if (m_pop) void'(exp_q.pop_front());
        if (m_pend) begin
          if (exp_q.size() == D && !m_pop) m_ovf = 1;
          else exp_q.push_back(m_pend_e);
        end
        m_pend = 0;
        m_acc = (m_mode != 0) && validin && !blanking_in;
        m_fin = m_acc && (m_pcount == FRAME - 1);
        if (m_acc) begin
          m_pix.push_back(din);
          if (m_pix.size() == 4) begin
            m_e.data = {m_pix[3], m_pix[2], m_pix[1], m_pix[0]};
            m_e.eol  = ((m_pcount + 1) % W) == 0;
            m_e.eof  = (m_pcount == FRAME - 1);
            m_pend   = 1;
            m_pend_e = m_e;
            m_pix.delete();
          end
          m_pcount = (m_pcount + 1) % FRAME;
        end
        case (m_mode)
          0: if (enable) m_mode = 1;
          1: if (!enable) m_mode = m_fin ? 0 : 2;
          default: begin
            if (m_fin) m_mode = 0;
            else if (enable) m_mode = 1;
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    validin     = 1'b0;
    blanking_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d);
    din         = d;
    validin     = 1'b1;
    blanking_in = 1'b0;
    step();
    validin = 1'b0;
  endtask

  task automatic noise();
    int k;
    k = $urandom_range(0, 3);
    repeat (k) begin
      din         = 8'($urandom);
      validin     = $urandom_range(0, 1) == 1;
      blanking_in = 1'b1;
      if (!validin && $urandom_range(0, 1) == 1) blanking_in = 1'b0;
      step();
    end
    validin     = 1'b0;
    blanking_in = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    validin     = 1'b0;
    blanking_in = 1'b0;
    word_ready  = 1'b0;
    @(negedge clock);
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_eol", word_eol, 0);
    chk("rst_eof", word_eof, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int t;

    // First word and its two-cycle latency.
    do_reset();
    enable     = 1'b1;
    word_ready = 1'b1;
    idle(1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    @(negedge clock);
    chk("latency_cycle1", word_valid, 0);
    @(negedge clock);
    chk("latency_cycle2", word_valid, 1);
    chk("first_word", word_data, 32'h04030201);
    step();

    // Blanking samples and gaps between pixels must not disturb the word.
    do_reset();
    enable     = 1'b1;
    word_ready = 1'b1;
    idle(1);
    base = n_hs;
    for (int i = 1; i <= 4; i++) begin
      noise();
      send(8'(i));
    end
    noise();
    idle(4);
    chk("blank_words", n_hs - base, 1);
    chk("blank_word", last_data, 32'h04030201);

    // Full 8x2 frame: four words, eol on words 2 and 4, eof on word 4.
    do_reset();
    enable     = 1'b1;
    word_ready = 1'b1;
    idle(1);
    base = n_hs;
    n_eol = 0;
    n_eof = 0;
    for (int p = 0; p < 16; p++) begin
      send(8'(8'h10 + p));
      noise();
    end
    idle(5);
    chk("frame_words", n_hs - base, 4);
    chk("frame_eol", n_eol, 2);
    chk("frame_eof", n_eof, 1);
    chk("frame_last_eof", last_eof, 1);

    // Overflow: five words into a stalled depth-4 FIFO, then push+pop while full.
    do_reset();
    enable = 1'b1;
    idle(1);
    for (int p = 0; p < 20; p++) send(8'(8'h40 + p));
    idle(3);
    chk("ovf_set", overflow, 1);
    base = n_hs;
    for (int p = 20; p < 24; p++) send(8'(8'h40 + p));
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    idle(2);
    chk("ovf_simul_pop", n_hs - base, 1);
    word_ready = 1'b1;
    idle(10);
    chk("ovf_drained", n_hs - base, 5);
    chk("ovf_last_word", last_data, 32'h57565554);
    chk("ovf_sticky", overflow, 1);

    // Enable dropped mid-frame: finish the frame, then go idle and ignore pixels.
    do_reset();
    enable     = 1'b1;
    word_ready = 1'b1;
    idle(1);
    base = n_hs;
    for (int p = 0; p < 5; p++) send(8'(8'h80 + p));
    enable = 1'b0;
    idle(2);
    chk("stop_busy_early", busy, 1);
    for (int p = 5; p < 15; p++) send(8'(8'h80 + p));
    chk("stop_busy_late", busy, 1);
    send(8'h8F);
    chk("stop_idle", busy, 0);
    for (int p = 0; p < 4; p++) send(8'hC0);
    idle(5);
    chk("stop_words", n_hs - base, 4);
    chk("stop_last", last_data, 32'h8F8E8D8C);

    // Reset with a half-built word: the next four pixels start at lane 0.
    do_reset();
    enable     = 1'b1;
    word_ready = 1'b1;
    idle(1);
    send(8'h77);
    send(8'h78);
    do_reset();
    base       = n_hs;
    enable     = 1'b1;
    word_ready = 1'b1;
    idle(1);
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    send(8'hA4);
    idle(4);
    chk("rst_mid_words", n_hs - base, 1);
    chk("rst_mid_word", last_data, 32'hA4A3A2A1);

    // Randomized traffic with enable toggling, stalls and a mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      enable      = $urandom_range(0, 9) != 0;
      word_ready  = $urandom_range(0, 9) < 6;
      validin     = $urandom_range(0, 9) < 7;
      blanking_in = $urandom_range(0, 9) < 2;
      din         = 8'($urandom);
      step();
    end
    enable      = 1'b0;
    validin     = 1'b0;
    blanking_in = 1'b0;
    word_ready  = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || word_valid) && t < 100) begin
      step();
      t++;
    end
    chk("drain_bound", 32'(t < 100), 1);
    chk("drain_valid", word_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_stream_packer.md
WINDOW_STREAM_PACKER -- requirements
Module: window_stream_packer

Interface
REQ-001 SHALL have parameter width, default 420: accepted pixels per line; a multiple of 4.
REQ-002 SHALL have parameter height, default 240: lines per frame.
REQ-003 SHALL have parameter depth, default 4: word FIFO entries; a power of 2.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port din  input  8  pixel from the 5x5 window output stream.
REQ-007 SHALL have port blanking_in  input  1  marks din as a blanking sample, not a pixel.
REQ-008 SHALL have port validin  input  1  din/blanking_in qualifier; the input has no backpressure.
REQ-009 SHALL have port enable  input  1  request to pack frames.
REQ-010 SHALL have port word_data  output  32  packed word; first pixel in bits [7:0].
REQ-011 SHALL have port word_valid  output  1  word_data valid (FIFO not empty).
REQ-012 SHALL have port word_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port word_eol  output  1  head word is the last word of a line.
REQ-014 SHALL have port word_eof  output  1  head word is the last word of a frame.
REQ-015 SHALL have port overflow  output  1  sticky flag: a packed word was dropped.
REQ-016 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-017 SHALL accept a pixel only when validin=1, blanking_in=0 and state is ACTIVE or STOPPING; all other samples are ignored.
REQ-018 SHALL place accepted pixels into byte lanes 0,1,2,3 in order, and push the word into the FIFO on the cycle after the 4th pixel is accepted.
REQ-019 SHALL count accepted pixels with x_count (0..width-1) and wrap it to 0 after width-1.
REQ-020 SHALL increment y_count on each x wrap and wrap it to 0 after height-1.
REQ-021 SHALL push the eol/eof tag bits into the FIFO alongside each word: eol when x_count=width-1, eof when additionally y_count=height-1.
REQ-022 SHALL pop the FIFO head on any cycle where word_valid=1 and word_ready=1.
REQ-023 SHALL drive word_data, word_eol and word_eof from the FIFO head and hold them stable while word_valid=1 and word_ready=0.
REQ-024 SHALL, on a push with the FIFO full and no pop that cycle, drop the word, set overflow, and leave x_count/y_count advancing normally.
REQ-025 SHALL, on a push and a pop in the same cycle with the FIFO full, accept the push without setting overflow.
REQ-026 SHALL latch a pushed word so that word_valid rises one cycle after the push when the FIFO is empty; total latency from the 4th pixel to word_valid is 2 cycles.
REQ-027 SHALL implement FSM IDLE, ACTIVE, STOPPING with these transitions:
- IDLE -> ACTIVE when enable=1.
- ACTIVE -> STOPPING when enable=0 and the frame is not at its final pixel.
- ACTIVE -> IDLE when enable=0 on the cycle the final pixel (x=width-1, y=height-1) is accepted.
- STOPPING -> IDLE when the final pixel is accepted.
- STOPPING -> ACTIVE if enable returns to 1.
REQ-028 SHALL hold x_count, y_count and the byte-lane index at 0 while in IDLE.
REQ-029 SHALL keep draining the FIFO in IDLE.
REQ-030 SHALL clear overflow only by reset.

Reset
REQ-031 SHALL, on reset, force: state IDLE, x_count=0, y_count=0, lane index=0, FIFO empty, word_valid=0, word_eol=0, word_eof=0, overflow=0, busy=0, word_data=0.
REQ-032 SHALL, on reset asserted mid-frame, discard the partial word and all FIFO contents; the next frame starts at lane 0.

Structure
REQ-033 SHALL take the state encoding (IDLE, ACTIVE, STOPPING) and the word-width constant (32) from the shared package.
REQ-034 SHALL instantiate one sub-module, word_fifo: a synchronous FIFO of depth entries of 34 bits (data, eol, eof) with full and empty outputs.

Verification
REQ-035 SHALL cover: enable=1, pixels 0x01,0x02,0x03,0x04 valid and unblanked -> word_data=0x04030201, word_valid high 2 cycles after 0x04.
REQ-036 SHALL cover: interleave blanking samples and validin=0 gaps between pixels -> identical words; blanked samples never appear in the output.
REQ-037 SHALL cover: a full frame with width=8, height=2 and word_ready=1 -> 4 words; eol on words 2 and 4; eof on word 4 only.
REQ-038 SHALL cover: word_ready=0 with depth=4, then push 5 words -> overflow=1, words 1-4 retained in order, word 5 lost; then a push with a simultaneous pop when full -> no further drop.
REQ-039 SHALL cover: enable dropped mid-frame -> busy stays 1 until the final pixel of the frame is accepted, then IDLE; pixels after that are ignored.
REQ-040 SHALL cover: reset after 2 pixels of a word -> no word emitted; the next 4 pixels form a fresh word starting at lane 0.
